// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage in front of a combinational ALU: accepts one instruction at a time,
// reads operands from a 4-entry register file, drives registered ALU inputs and writes back.
module alu_issue_ctrl #(
  parameter int unsigned LEN      = 8,
  parameter int unsigned MAX_CODE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic           instr_load,
  input  logic [3:0]     instr_code,
  input  logic [1:0]     instr_rd,
  input  logic [1:0]     instr_ra,
  input  logic [1:0]     instr_rb,
  input  logic [LEN-1:0] instr_imm,
  output logic [LEN-1:0] alu_a,
  output logic [LEN-1:0] alu_b,
  output logic [3:0]     alu_code,
  input  logic [LEN-1:0] alu_out,
  output logic           done,
  output logic           err,
  output logic [LEN-1:0] result,
  input  logic [1:0]     dbg_sel,
  output logic [LEN-1:0] dbg_data
);

  typedef enum logic [2:0] {
    StIdle,
    StOperand,
    StExecute,
    StWrite,
    StReject
  } state_e;

  // Codes wider than the 4-bit field can never be illegal.
  localparam logic [4:0] MaxCode = (MAX_CODE > 15) ? 5'd15 : 5'(MAX_CODE);

  state_e                  state_q, state_d;
  logic [3:0][LEN-1:0]     regs_q;
  logic [3:0]              code_q;
  logic [1:0]              rd_q, ra_q, rb_q;
  logic [LEN-1:0]          wval_q;
  logic                    xfer;

  // Gated with rst_n so ready is low for the whole time reset is held.
  assign instr_ready = (state_q == StIdle) && rst_n;
  assign xfer        = instr_valid && instr_ready;
  assign dbg_data    = regs_q[dbg_sel];

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          if (instr_load) begin
            state_d = StWrite;
          end else if ({1'b0, instr_code} > MaxCode) begin
            state_d = StReject;
          end else begin
            state_d = StOperand;
          end
        end
      end
      StOperand: state_d = StExecute;
      StExecute: state_d = StWrite;
      StWrite: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StReject: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      regs_q   <= '0;
      code_q   <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      wval_q   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_code <= '0;
      result   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        code_q <= instr_code;
        rd_q   <= instr_rd;
        ra_q   <= instr_ra;
        rb_q   <= instr_rb;
        wval_q <= instr_imm;
      end
      // Operands are sampled before any write-back, so rd aliasing ra/rb reads the old value.
      if (state_q == StOperand) begin
        alu_a    <= regs_q[ra_q];
        alu_b    <= regs_q[rb_q];
        alu_code <= code_q;
      end
      if (state_q == StExecute) begin
        wval_q <= alu_out;
      end
      if (state_q == StWrite) begin
        regs_q[rd_q] <= wval_q;
        result       <= wval_q;
      end
    end
  end

endmodule
